// File: rtl/qbus_slave_cycle.sv
// QBUS slave data-transfer sequencer: synchronizes bus strobes, latches address/data,
// and sequences DATI / DATO(B) / DATIO(B) cycles against a single decoding device.
module qbus_slave_cycle #(
  parameter int unsigned READ_DELAY = 2
) (
  input  logic        qclk,
  input  logic        reset_n,
  input  logic [21:0] RDAL,
  input  logic        RBS7_in,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RWTBT,
  input  logic        RINIT,
  output logic [21:0] RAL,
  output logic        RBS7,
  output logic [15:0] RDL,
  output logic        write_byte,
  output logic        write_pulse,
  input  logic        addr_match,
  input  logic [15:0] TDL,
  output logic [15:0] TDAL,
  output logic        tdal_oe,
  output logic        TRPLY
);

  typedef enum logic [2:0] {
    IDLE, DECODE, NOMATCH, ARMED, RDRIVE, WPULSE, RELEASE, WAITSYNC
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_DELAY);

  logic [1:0] sync_r, din_r, dout_r, init_r, wtbt_r;
  logic       sync, din, dout, init, wtbt;
  logic       sync_low_seen;
  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       trply_d, oe_d, wp_d;
  logic       rd_cyc, rd_cyc_d;
  logic       ld_rdl;

  assign sync = sync_r[1];
  assign din  = din_r[1];
  assign dout = dout_r[1];
  assign init = init_r[1];
  assign wtbt = wtbt_r[1];

  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      din_r  <= '0;
      dout_r <= '0;
      init_r <= '0;
      wtbt_r <= '0;
    end else begin
      sync_r <= {sync_r[0], RSYNC};
      din_r  <= {din_r[0],  RDIN};
      dout_r <= {dout_r[0], RDOUT};
      init_r <= {init_r[0], RINIT};
      wtbt_r <= {wtbt_r[0], RWTBT};
    end
  end

  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      TRPLY         <= 1'b0;
      tdal_oe       <= 1'b0;
      write_pulse   <= 1'b0;
      rd_cyc        <= 1'b0;
      sync_low_seen <= 1'b0;
      RAL           <= '0;
      RBS7          <= 1'b0;
      RDL           <= '0;
      write_byte    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      TRPLY       <= trply_d;
      tdal_oe     <= oe_d;
      write_pulse <= wp_d;
      rd_cyc      <= rd_cyc_d;
      // A SYNC already high when leaving reset/INIT must drop before it can start a cycle.
      if (init)
        sync_low_seen <= 1'b0;
      else if (!sync)
        sync_low_seen <= 1'b1;
      if (state == IDLE && sync_low_seen && RSYNC && !sync_r[0] && !init) begin
        RAL  <= RDAL;
        RBS7 <= RBS7_in;
      end
      if (ld_rdl) begin
        RDL        <= RDAL[15:0];
        write_byte <= wtbt;
      end
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    trply_d  = 1'b0;
    oe_d     = 1'b0;
    wp_d     = 1'b0;
    rd_cyc_d = rd_cyc;
    ld_rdl   = 1'b0;
    if (init) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE:     if (sync && sync_low_seen) state_d = DECODE;
        DECODE:   state_d = addr_match ? ARMED : NOMATCH;
        NOMATCH:  if (!sync) state_d = IDLE;
        ARMED: begin
          if (din) begin
            state_d  = RDRIVE;
            oe_d     = 1'b1;
            cnt_d    = RD_LOAD;
            rd_cyc_d = 1'b1;
          end else if (dout) begin
            state_d  = WPULSE;
            wp_d     = 1'b1;
            trply_d  = 1'b1;
            ld_rdl   = 1'b1;
            rd_cyc_d = 1'b0;
          end else if (!sync) begin
            state_d = IDLE;
          end
        end
        RDRIVE: begin
          oe_d = 1'b1;
          if (cnt <= 4'd1) begin
            cnt_d   = '0;
            trply_d = 1'b1;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end
        WPULSE: begin
          trply_d = 1'b1;
          state_d = RELEASE;
        end
        RELEASE: begin
          if (rd_cyc ? din : dout) begin
            trply_d = 1'b1;
            oe_d    = rd_cyc;
          end else begin
            state_d = WAITSYNC;
          end
        end
        WAITSYNC: state_d = sync ? ARMED : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign TDAL = tdal_oe ? TDL : '0;

endmodule

// File: tb/tb_qbus_slave_cycle.sv
// Scoreboard bench for qbus_slave_cycle: expected reads/writes are queued at stimulus
// time and checked when the DUT replies or pulses write_pulse.
module tb_qbus_slave_cycle;

  localparam int unsigned READ_DELAY = 2;
  localparam logic [21:0] BASE  = 22'o17777570;
  localparam logic [21:0] OTHER = 22'o17777600;

  logic        qclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [21:0] RDAL = '0;
  logic        RBS7_in = 1'b0;
  logic        RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RWTBT = 1'b0, RINIT = 1'b0;
  logic [21:0] RAL;
  logic        RBS7;
  logic [15:0] RDL;
  logic        write_byte, write_pulse;
  logic        addr_match;
  logic [15:0] TDL = '0;
  logic [15:0] TDAL;
  logic        tdal_oe, TRPLY;

  assign addr_match = (RAL[21:1] == BASE[21:1]) && RBS7;

  qbus_slave_cycle #(.READ_DELAY(READ_DELAY)) dut (
    .qclk(qclk), .reset_n(reset_n), .RDAL(RDAL), .RBS7_in(RBS7_in),
    .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RWTBT(RWTBT), .RINIT(RINIT),
    .RAL(RAL), .RBS7(RBS7), .RDL(RDL), .write_byte(write_byte),
    .write_pulse(write_pulse), .addr_match(addr_match), .TDL(TDL),
    .TDAL(TDAL), .tdal_oe(tdal_oe), .TRPLY(TRPLY)
  );

  always #25 qclk = ~qclk;

  typedef struct {
    logic [15:0] data;
    logic        wb;
    logic        ral0;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] rq[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, act_cnt = 0;
  int strobe_rise_cyc = 0, strobe_fall_cyc = 0, oe_rise_cyc = 0;
  logic trply_q = 1'b0, oe_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge qclk) begin
    #1;
    cyc++;
    if (TRPLY || tdal_oe || write_pulse) act_cnt++;
    if (tdal_oe && !oe_q) oe_rise_cyc = cyc;
    if (write_pulse) begin
      if (wq.size() == 0) check("wp_unexpected", 1, 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        check("wp_rdl", 32'(RDL), 32'(e.data));
        check("wp_byte", 32'(write_byte), 32'(e.wb));
        check("wp_ral0", 32'(RAL[0]), 32'(e.ral0));
        check("wp_trply", 32'(TRPLY), 1);
      end
    end
    if (TRPLY && !trply_q) begin
      if (tdal_oe) begin
        if (rq.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_tdal", 32'(TDAL), 32'(rq.pop_front()));
        check("rd_lat", 32'(cyc - strobe_rise_cyc), 32'(3 + READ_DELAY));
        check("oe_lead", 32'(cyc - oe_rise_cyc), 32'(READ_DELAY));
      end else begin
        check("wr_lat", 32'(cyc - strobe_rise_cyc), 3);
      end
    end
    if (!TRPLY && trply_q) begin
      check("neg_lat", 32'(cyc - strobe_fall_cyc), 3);
      check("oe_neg", 32'(tdal_oe), 0);
    end
    trply_q = TRPLY;
    oe_q    = tdal_oe;
  end

  task automatic wait_trply(input logic val, input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge qclk);
      if (TRPLY === val) seen = 1;
    end
    if (!seen) check(tag, 32'(TRPLY), 32'(val));
  endtask

  task automatic start_sync(input logic [21:0] addr, input logic bs7);
    @(negedge qclk);
    RDAL = addr; RBS7_in = bs7;
    @(negedge qclk);
    RSYNC = 1'b1;
    repeat (4) @(negedge qclk);
  endtask

  task automatic end_sync();
    RSYNC = 1'b0; RWTBT = 1'b0;
    repeat (4) @(negedge qclk);
  endtask

  task automatic read_phase(input logic [15:0] val);
    TDL = val;
    rq.push_back(val);
    RDIN = 1'b1;
    strobe_rise_cyc = cyc;
    wait_trply(1'b1, "rd_timeout");
    @(negedge qclk);
    RDIN = 1'b0;
    strobe_fall_cyc = cyc;
    wait_trply(1'b0, "rd_release_timeout");
    @(negedge qclk);
  endtask

  task automatic write_phase(input logic [15:0] data, input logic wb, input logic ral0,
                             input int hold);
    wr_t e;
    e.data = data; e.wb = wb; e.ral0 = ral0;
    wq.push_back(e);
    RDAL = {6'b0, data};
    RWTBT = wb;
    RDOUT = 1'b1;
    strobe_rise_cyc = cyc;
    wait_trply(1'b1, "wr_timeout");
    repeat (hold) @(negedge qclk);
    RDOUT = 1'b0;
    strobe_fall_cyc = cyc;
    wait_trply(1'b0, "wr_release_timeout");
    @(negedge qclk);
  endtask

  initial begin
    int a0;
    repeat (2) @(negedge qclk);
    check("rst_ral", 32'(RAL), 0);
    check("rst_rdl", 32'(RDL), 0);
    check("rst_outs", 32'({TRPLY, tdal_oe, write_pulse, write_byte, RBS7}), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge qclk);

    // DATI to the device base address
    start_sync(BASE, 1'b1);
    check("dati_ral", 32'(RAL), 32'(BASE));
    check("dati_bs7", 32'(RBS7), 1);
    read_phase(16'o000777);
    end_sync();

    // reset in the middle of RDRIVE, SYNC left asserted through and after reset
    start_sync(BASE, 1'b1);
    TDL = 16'o052525;
    RDIN = 1'b1;
    for (int i = 0; i < 20 && !tdal_oe; i++) @(negedge qclk);
    check("mid_oe", 32'(tdal_oe), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_outs", 32'({TRPLY, tdal_oe, write_pulse}), 0);
    check("async_rst_tdal", 32'(TDAL), 0);
    check("async_rst_ral", 32'(RAL), 0);
    RDIN = 1'b0;
    @(negedge qclk);
    reset_n = 1'b1;
    repeat (6) @(negedge qclk);
    a0 = act_cnt;
    RDIN = 1'b1;
    repeat (8) @(negedge qclk);
    RDIN = 1'b0;
    repeat (4) @(negedge qclk);
    check("held_sync_ignored", 32'(act_cnt - a0), 0);
    check("held_sync_ral", 32'(RAL), 0);
    end_sync();

    // DATO word, DOUT held 20 cycles
    start_sync(BASE, 1'b1);
    write_phase(16'o123456, 1'b0, 1'b0, 20);
    end_sync();
    check("dato_rdl_hold", 32'(RDL), 32'(16'o123456));

    // DATOB odd byte
    start_sync(BASE | 22'd1, 1'b1);
    write_phase(16'o000252, 1'b1, 1'b1, 2);
    end_sync();

    // non-matching address, strobes toggled
    start_sync(OTHER, 1'b1);
    a0 = act_cnt;
    RDIN = 1'b1; repeat (8) @(negedge qclk); RDIN = 1'b0; repeat (4) @(negedge qclk);
    RDAL = {6'b0, 16'o177777}; RDOUT = 1'b1;
    repeat (8) @(negedge qclk);
    RDOUT = 1'b0; repeat (4) @(negedge qclk);
    check("nomatch_quiet", 32'(act_cnt - a0), 0);
    check("nomatch_rdl_hold", 32'(RDL), 32'(16'o000252));
    end_sync();
    start_sync(BASE, 1'b1);
    read_phase(16'o001234);
    end_sync();

    // DATIO: read then write under one SYNC
    start_sync(BASE, 1'b1);
    read_phase(16'o070707);
    write_phase(16'o012345, 1'b0, 1'b0, 3);
    check("datio_ral", 32'(RAL), 32'(BASE));
    end_sync();

    // DATIO with INIT arriving together with the write strobe
    start_sync(BASE, 1'b1);
    read_phase(16'o007070);
    a0 = act_cnt;
    RDAL = {6'b0, 16'o111111}; RDOUT = 1'b1; RINIT = 1'b1;
    repeat (10) @(negedge qclk);
    check("init_no_write", 32'(act_cnt - a0), 0);
    RINIT = 1'b0; RDOUT = 1'b0;
    end_sync();
    start_sync(BASE, 1'b1);
    check("post_init_ral", 32'(RAL), 32'(BASE));
    read_phase(16'o000001);
    end_sync();

    repeat (4) @(negedge qclk);
    check("wq_empty", 32'(wq.size()), 0);
    check("rq_empty", 32'(rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
